// File: rtl/reg_pipe_ce_arn.sv
// reg_pipe_ce_arn: elastic multi-stage register pipeline with clock enable,
// synchronous flush, asynchronous active-low reset and an occupancy count.
// A chain of DEPTH data/valid stages carries WIDTH-bit words from In0 to
// Out0. Empty stages (bubbles) are collapsed so that a stalled consumer only
// blocks the input once every stage holds a word.
//
// Handshake: a word moves across an interface on a rising edge exactly when
// valid and ready are both 1 in the cycle before that edge. A producer keeps
// valid and data stable until ready is seen. in_ready depends
// combinationally on out_ready through the whole chain. out_valid does not
// depend on in_valid, and in_ready does not depend on in_valid.
module reg_pipe_ce_arn #(
    parameter int               WIDTH = 16,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                         CLK,
    input  logic                         ASYNCRESETN,
    input  logic                         CE,
    input  logic                         CLR,
    input  logic [WIDTH-1:0]             In0,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             Out0,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] inc_v;
    logic [WIDTH-1:0] inc_d [DEPTH];
    logic             push;
    logic             pop;

    // Advance terms: a stage may load when it is empty or its successor
    // moves on; the last stage moves on when the consumer is ready.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = CE & ~CLR & (~v[DEPTH-1] | out_ready);
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = CE & ~CLR & (~v[i] | adv[i+1]);
        end
    end

    // Incoming word for each stage: the input port for stage 0, the
    // previous stage otherwise.
    always_comb begin
        inc_v[0] = in_valid;
        inc_d[0] = In0;
        for (int i = 1; i < DEPTH; i++) begin
            inc_v[i] = v[i-1];
            inc_d[i] = d[i-1];
        end
    end

    assign in_ready  = adv[0] & ASYNCRESETN;
    assign out_valid = v[DEPTH-1] & ~CLR;
    assign Out0      = d[DEPTH-1];

    // A pop only happens when the last stage really advances, so a frozen
    // pipeline (CE=0) never loses its output word.
    assign push = in_valid & in_ready;
    assign pop  = v[DEPTH-1] & adv[DEPTH-1];

    // Stage registers: valid always follows on advance, data only loads
    // real words so bubbles leave the data bits untouched.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= INIT;
            end
        end else if (CLR) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d[i] <= INIT;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v[i] <= inc_v[i];
                    if (inc_v[i]) begin
                        d[i] <= inc_d[i];
                    end
                end
            end
        end
    end

    // Occupancy: tracks the number of valid stages by counting transfers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_pipe_ce_arn.sv
// Bench for reg_pipe_ce_arn (WIDTH=16, DEPTH=3, INIT=16'hA5A5).
// Driver tasks push accepted words into exp_q; an independent monitor pops
// and compares whenever an output transfer happens.
module tb_reg_pipe_ce_arn;
  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
  localparam logic [WIDTH-1:0] INIT = 16'hA5A5;
  localparam int CW = $clog2(DEPTH+1);

  // clock / reset
  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = clk_run ? ~clk : clk;

  logic ce = 1'b1;
  logic clr = 1'b0;
  logic [WIDTH-1:0] in0 = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [WIDTH-1:0] out0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [CW-1:0] count;

  reg_pipe_ce_arn #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .CLK(clk), .ASYNCRESETN(rst_n), .CE(ce), .CLR(clr),
    .In0(in0), .in_valid(in_valid), .in_ready(in_ready),
    .Out0(out0), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [WIDTH-1:0] exp_q[$];
  int out_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && ce && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_extra: got %0h expected no output", out0);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out0 !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h", out0, e);
        end
      end
      out_cyc_q.push_back(cyc);
    end
  end

  // driver: offer one word until accepted (bounded)
  task automatic drive_word(input logic [WIDTH-1:0] val, output int acc);
    bit done;
    done = 1'b0;
    acc = -1;
    in0 = val;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(val);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (done) acc = cyc;
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no in_ready expected accept of %0h", val);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 30 && exp_q.size() != 0; t++) begin
      @(negedge clk); #2;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int k0, a8, a9, dummy;

    // 1: reset with no clock running
    #3 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out0", out0, 16'hA5A5);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 0);
    #5 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_count", count, 0);
    clk_run = 1'b1;
    @(posedge clk); #1;

    // 2: streaming
    out_ready = 1'b1;
    out_cyc_q.delete();
    drive_word(16'd1, k0);
    drive_word(16'd2, dummy);
    drive_word(16'd3, dummy);
    drive_word(16'd4, dummy);
    @(negedge clk);
    check("stream_count", count, 3);
    @(posedge clk); #1;
    wait_drain();
    check("stream_n_out", out_cyc_q.size(), 4);
    if (out_cyc_q.size() == 4) begin
      check("stream_latency", out_cyc_q[0], k0 + 2);
      check("stream_b2b", out_cyc_q[3], k0 + 5);
    end
    check("empty_count", count, 0);

    // 3: backpressure and fill
    out_ready = 1'b0;
    drive_word(16'd10, dummy);
    drive_word(16'd11, dummy);
    drive_word(16'd12, dummy);
    in0 = 16'd13;
    in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    check("full_count", count, 3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_word(16'd13, dummy);
    @(negedge clk);
    check("simul_count", count, 3);
    @(posedge clk); #1;
    wait_drain();

    // 4: bubble collapse
    out_ready = 1'b0;
    drive_word(16'd7, dummy);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bub_out_valid", out_valid, 1);
    check("bub_out0", out0, 7);
    check("bub_count1", count, 1);
    @(posedge clk); #1;
    drive_word(16'd8, a8);
    drive_word(16'd9, a9);
    check("bub_consecutive", a9, a8 + 1);
    @(negedge clk);
    check("bub_count3", count, 3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // 5: CE freeze then CLR flush
    out_ready = 1'b0;
    drive_word(16'd20, dummy);
    drive_word(16'd21, dummy);
    @(posedge clk); #1;
    ce = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ce0_in_ready", in_ready, 0);
      check("ce0_count", count, 2);
      check("ce0_out_valid", out_valid, 1);
      check("ce0_out0", out0, 20);
      @(posedge clk); #1;
    end
    ce = 1'b1;
    clr = 1'b1;
    in0 = 16'd99;
    in_valid = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_count", count, 0);
    check("clr_out0", out0, 16'hA5A5);
    check("clr_out_valid_after", out_valid, 0);
    repeat (5) @(posedge clk);
    #1;

    // 6: reset mid-operation with a full pipe
    out_ready = 1'b0;
    drive_word(16'd30, dummy);
    drive_word(16'd31, dummy);
    drive_word(16'd32, dummy);
    @(negedge clk); #2;
    check("pre_rst_count", count, 3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out0", out0, 16'hA5A5);
    check("mid_rst_count", count, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_mid_rst_count", count, 0);
    drive_word(16'd40, dummy);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
